multi_extremum_finder: RTL and testbench

Windowed signed min/max detector for CHANNEL_COUNT interleaved sample channels. It sits after the demodulation stage on an AXI-Stream sample bus. Over each window of 2^EF_log_count valid samples it emits one result beat per window, carrying the scaled maximum and minimum of every channel. The output uses a full AXI-Stream handshake with overrun detection.

---
 rtl/multi_extremum_finder_pkg.sv | 15 +
 rtl/multi_extremum_finder_if.sv | 18 +
 rtl/multi_extremum_finder_channel.sv | 70 +++++++
 rtl/multi_extremum_finder.sv | 135 +++++++++++++
 tb/tb_multi_extremum_finder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/multi_extremum_finder_pkg.sv
// Shared types and helpers for the windowed multi-channel min/max detector.
package multi_extremum_finder_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int unsigned DEFAULT_SAMPLE_WIDTH  = 16;
  localparam int unsigned DEFAULT_MAX_LOG_COUNT = 16;

  function automatic logic [4:0] clamp_log(input logic [4:0] log_count,
                                           input int unsigned max_log);
    if (32'(log_count) > max_log) return 5'(max_log);
    return log_count;
  endfunction

endpackage

// File: rtl/multi_extremum_finder_if.sv
// AXI-Stream style bundle; tuser exists only when EF_INDEX_EN is defined.
interface multi_extremum_finder_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned UserWidth = 1
);
  logic [DataWidth-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
`ifdef EF_INDEX_EN
  logic [UserWidth-1:0] tuser;

  modport master (output tdata, output tvalid, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tuser, output tready);
`else
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/multi_extremum_finder_channel.sv
// Running signed min/max of one channel; first-occurrence indices under EF_INDEX_EN.
// max_val/min_val already include the current cycle's sample.
module extremum_channel
  import multi_extremum_finder_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH  = DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned MAX_LOG_COUNT = DEFAULT_MAX_LOG_COUNT
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           first,
  input  logic                           valid,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
`ifdef EF_INDEX_EN
  input  logic [MAX_LOG_COUNT-1:0]       index,
  output logic [MAX_LOG_COUNT-1:0]       max_index,
  output logic [MAX_LOG_COUNT-1:0]       min_index,
`endif
  output logic signed [SAMPLE_WIDTH-1:0] max_val,
  output logic signed [SAMPLE_WIDTH-1:0] min_val
);

  logic signed [SAMPLE_WIDTH-1:0] max_q, min_q;
`ifdef EF_INDEX_EN
  logic [MAX_LOG_COUNT-1:0] max_idx_q, min_idx_q;
`endif

  // Strict compares keep the stored value on a tie, i.e. the first occurrence.
  always_comb begin
    max_val = max_q;
    min_val = min_q;
`ifdef EF_INDEX_EN
    max_index = max_idx_q;
    min_index = min_idx_q;
`endif
    if (valid) begin
      if (first || sample > max_q) begin
        max_val = sample;
`ifdef EF_INDEX_EN
        max_index = index;
`endif
      end
      if (first || sample < min_q) begin
        min_val = sample;
`ifdef EF_INDEX_EN
        min_index = index;
`endif
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      max_q <= '0;
      min_q <= '0;
`ifdef EF_INDEX_EN
      max_idx_q <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      max_q <= max_val;
      min_q <= min_val;
`ifdef EF_INDEX_EN
      max_idx_q <= max_index;
      min_idx_q <= min_index;
`endif
    end
  end

endmodule

// File: rtl/multi_extremum_finder.sv
// Windowed signed min/max over 2^N valid samples per channel, one result beat per window.
// Defining EF_INDEX_EN adds per-channel extremum indices on M_AXIS tuser.
module multi_extremum_finder
  import multi_extremum_finder_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH  = DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned CHANNEL_COUNT = 2,
  parameter int unsigned MAX_LOG_COUNT = DEFAULT_MAX_LOG_COUNT
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [4:0]              EF_log_count,
  input  logic [2:0]              EF_shift,
  multi_extremum_finder_if.slave  s_axis,
  multi_extremum_finder_if.master m_axis,
  output logic                    overrun
);

  localparam int unsigned CntW = MAX_LOG_COUNT + 1;
  localparam int unsigned OutW = 2 * CHANNEL_COUNT * SAMPLE_WIDTH;

  state_e            state_q, state_d;
  logic [4:0]        n, n_q;
  logic [CntW-1:0]   cnt_q, cnt_d, limit;
  logic              accept, first, win_end;
  logic [OutW-1:0]   res, tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d, overrun_q, overrun_d;
`ifdef EF_INDEX_EN
  localparam int unsigned UserW = 2 * CHANNEL_COUNT * MAX_LOG_COUNT;
  logic [UserW-1:0]  idx_res, tuser_q, tuser_d;
`endif

  assign n     = clamp_log(EF_log_count, MAX_LOG_COUNT);
  assign limit = (CntW'(1) << n_q) - CntW'(1);
  assign first = (cnt_q == '0);

  // A change of exponent while running throws away the partial window and that cycle's sample.
  always_comb begin
    state_d = (n == '0) ? IDLE : RUN;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: cnt_d = '0;
      RUN: begin
        if (n != n_q) begin
          cnt_d = '0;
        end else if (s_axis.tvalid) begin
          accept = 1'b1;
          cnt_d  = (cnt_q == limit) ? '0 : cnt_q + CntW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign win_end = accept && (cnt_q == limit);

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
    logic signed [SAMPLE_WIDTH-1:0] sample, max_v, min_v;
    assign sample = s_axis.tdata[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];

    extremum_channel #(
      .SAMPLE_WIDTH  (SAMPLE_WIDTH),
      .MAX_LOG_COUNT (MAX_LOG_COUNT)
    ) u_channel (
      .aclk      (aclk),
      .areset    (areset),
      .first     (first),
      .valid     (accept),
      .sample    (sample),
`ifdef EF_INDEX_EN
      .index     (cnt_q[MAX_LOG_COUNT-1:0]),
      .max_index (idx_res[(2*c+1)*MAX_LOG_COUNT +: MAX_LOG_COUNT]),
      .min_index (idx_res[2*c*MAX_LOG_COUNT +: MAX_LOG_COUNT]),
`endif
      .max_val   (max_v),
      .min_val   (min_v)
    );

    assign res[2*c*SAMPLE_WIDTH +: SAMPLE_WIDTH]     = min_v >>> EF_shift;
    assign res[(2*c+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = max_v >>> EF_shift;
  end

  always_comb begin
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    overrun_d = overrun_q;
`ifdef EF_INDEX_EN
    tuser_d   = tuser_q;
`endif
    if (win_end) begin
      tdata_d  = res;
      tvalid_d = 1'b1;
`ifdef EF_INDEX_EN
      tuser_d  = idx_res;
`endif
      if (tvalid_q && !m_axis.tready) overrun_d = 1'b1;
    end else if (m_axis.tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef EF_INDEX_EN
      tuser_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n;
      cnt_q     <= cnt_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      overrun_q <= overrun_d;
`ifdef EF_INDEX_EN
      tuser_q   <= tuser_d;
`endif
    end
  end

  assign s_axis.tready = 1'b1;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign overrun       = overrun_q;
`ifdef EF_INDEX_EN
  assign m_axis.tuser  = tuser_q;
`endif

endmodule

// File: tb/tb_multi_extremum_finder.sv
// Scoreboard bench for multi_extremum_finder (2 channels x 16 bit, MAX_LOG_COUNT 16).
module tb_multi_extremum_finder;

  logic       aclk;
  logic       areset;
  logic [4:0] EF_log_count;
  logic [2:0] EF_shift;
  logic       overrun;

  multi_extremum_finder_if #(.DataWidth(32), .UserWidth(1))  s_axis ();
  multi_extremum_finder_if #(.DataWidth(64), .UserWidth(64)) m_axis ();

`ifdef EF_INDEX_EN
  assign s_axis.tuser = '0;
`endif

  multi_extremum_finder #(
    .SAMPLE_WIDTH  (16),
    .CHANNEL_COUNT (2),
    .MAX_LOG_COUNT (16)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .EF_log_count (EF_log_count),
    .EF_shift     (EF_shift),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .overrun      (overrun)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] beat(input int mx0, input int mn0, input int mx1, input int mn1);
    return {16'(mx1), 16'(mn1), 16'(mx0), 16'(mn0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic smp(input int a, input int b);
    s_axis.tdata  = {16'(b), 16'(a)};
    s_axis.tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    s_axis.tvalid = 1'b0;
    repeat (cycles) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Each accepted output beat is compared against the oldest expectation.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge aclk);
      if (!areset && m_axis.tvalid && m_axis.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", m_axis.tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_axis.tdata !== e) begin
            errors++;
            $display("FAIL beat: got %h expected %h", m_axis.tdata, e);
          end
        end
      end
    end
  end

  initial begin : stim
    int a0[8];
    int a1[8];
    areset        = 1'b1;
    EF_log_count  = 5'd0;
    EF_shift      = 3'd0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    #12;
    check("reset_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("reset_tdata", m_axis.tdata, 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;

    // Basic window N=3 followed by a gapless second window
    EF_log_count = 5'd3;
    idle(1);
    exp_q.push_back(beat(40, -40, 8, 1));
    exp_q.push_back(beat(60, 40, -1, -8));
    a0 = '{-10, -30, -40, -20, 10, 20, 30, 40};
    a1 = '{1, 2, 3, 4, 5, 6, 7, 8};
    for (int i = 0; i < 8; i++) smp(a0[i], a1[i]);
    a0 = '{50, 60, 50, 40, 45, 55, 41, 42};
    a1 = '{-1, -2, -3, -4, -5, -6, -7, -8};
    for (int i = 0; i < 8; i++) smp(a0[i], a1[i]);

    // Arithmetic shift by 2
    EF_shift = 3'd2;
    exp_q.push_back(beat(10, -10, 2, 0));
    exp_q.push_back(beat(-2, -3, 25, 25));
    a0 = '{-10, -30, -40, -20, 10, 20, 30, 40};
    a1 = '{1, 2, 3, 4, 5, 6, 7, 8};
    for (int i = 0; i < 8; i++) smp(a0[i], a1[i]);
    a0 = '{-5, -6, -7, -8, -9, -10, -11, -12};
    for (int i = 0; i < 8; i++) smp(a0[i], 100);
    EF_shift     = 3'd0;
    EF_log_count = 5'd1;
    idle(1);

    // Window end coinciding with the handshake of the pending beat
    m_axis.tready = 1'b0;
    exp_q.push_back(beat(10, -10, 4, 4));
    exp_q.push_back(beat(7, 7, 9, -3));
    smp(10, 4);
    smp(-10, 4);
    smp(7, -3);
    m_axis.tready = 1'b1;
    smp(7, 9);
    check("coincide_overrun", 64'(overrun), 64'd0);
    idle(1);

    // Two window ends under backpressure: second result overwrites the first
    m_axis.tready = 1'b0;
    smp(3, 0);
    smp(7, 0);
    smp(-1, 2);
    smp(5, 2);
    check("overrun_set", 64'(overrun), 64'd1);
    check("overrun_tvalid", 64'(m_axis.tvalid), 64'd1);
    check("overrun_tdata", m_axis.tdata, beat(5, -1, 2, 2));
    exp_q.push_back(beat(5, -1, 2, 2));
    m_axis.tready = 1'b1;
    idle(1);

    // Disable mid-window: no beat
    EF_log_count = 5'd3;
    idle(1);
    smp(11, 11);
    smp(12, 12);
    smp(13, 13);
    EF_log_count = 5'd0;
    idle(4);

    // 3 -> 2 mid-window: junk and the change-cycle sample are dropped
    EF_log_count = 5'd3;
    idle(1);
    for (int i = 0; i < 5; i++) smp(1000, -1000);
    EF_log_count = 5'd2;
    smp(2000, -2000);
    exp_q.push_back(beat(4, 1, -1, -4));
    smp(1, -4);
    smp(2, -3);
    smp(3, -2);
    smp(4, -1);

    // Gapped tvalid, two independent channels, N=2
    exp_q.push_back(beat(5, -7, 200, -300));
    a0 = '{5, -7, 3, 2, 0, 0, 0, 0};
    a1 = '{-100, 200, -300, 50, 0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      smp(a0[i], a1[i]);
      idle(1);
    end

    // Reset with a pending result and a partial window
    m_axis.tready = 1'b0;
    for (int i = 0; i < 4; i++) smp(1, 1);
    smp(30, 30);
    smp(31, 31);
    #2;
    areset = 1'b1;
    #1;
    check("midreset_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("midreset_tdata", m_axis.tdata, 64'd0);
    check("midreset_overrun", 64'(overrun), 64'd0);
    @(posedge aclk);
    #1;
    m_axis.tready = 1'b1;
    areset        = 1'b0;
    idle(1);
    exp_q.push_back(beat(9, 6, 0, 0));
    smp(9, 0);
    smp(8, 0);
    smp(7, 0);
    smp(6, 0);

`ifdef EF_INDEX_EN
    idle(2);
    m_axis.tready = 1'b0;
    smp(5, 0);
    smp(9, 0);
    smp(9, 0);
    smp(1, 0);
    check("index_tuser", m_axis.tuser, 64'h0000_0000_0001_0003);
    exp_q.push_back(beat(9, 1, 0, 0));
    m_axis.tready = 1'b1;
`endif

    // Drain with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    idle(4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
